// File: rtl/layer_frames_arbiter_if.sv
// Stream bundle for the layer frame arbiter: per-layer input streams and the merged output stream.
interface layer_frames_arbiter_if #(
    parameter int LAYERS = 3
);
    logic [LAYERS*8-1:0] s_axis_tdata;
    logic [LAYERS*8-1:0] s_axis_tdest;
    logic [LAYERS-1:0]   s_axis_tlast;
    logic [LAYERS-1:0]   s_axis_tvalid;
    logic [LAYERS-1:0]   s_axis_tready;
    logic [7:0]          m_axis_tdata;
    logic [7:0]          m_axis_tdest;
    logic                m_axis_tlast;
    logic                m_axis_tvalid;
    logic                m_axis_tready;

    // Arbiter side: consumes the layer streams, produces the merged stream.
    modport slave (
        input  s_axis_tdata, s_axis_tdest, s_axis_tlast, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tdest, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

    // Environment side: feeds the layer streams, sinks the merged stream.
    modport master (
        output s_axis_tdata, s_axis_tdest, s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tdest, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/layer_frames_arbiter.sv
// Round-robin whole-frame arbiter merging LAYERS byte streams, with a mid-frame stall
// timeout that force-closes a frame by emitting an 8'hFF filler byte with tlast.
module layer_frames_arbiter #(
    parameter int LAYERS    = 3,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk_core,
    input  logic                 clk_core_rst,
    layer_frames_arbiter_if.slave axis,
    input  logic [LAYERS-1:0]    cfg_layer_enable,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    output logic [2:0]           status_grant,
    output logic                 status_busy,
    output logic [LAYERS-1:0]    stat_frame_done,
    output logic [LAYERS-1:0]    stat_timeout
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           grant_q, grant_d;
    logic [2:0]           last_grant_q, last_grant_d;
    logic [TIMEOUT_W-1:0] stall_q, stall_d;
    logic [LAYERS-1:0]    done_q, done_d;
    logic [LAYERS-1:0]    tout_q, tout_d;

    logic [LAYERS-1:0]    grant_oh_s;
    logic [LAYERS-1:0]    req_s;
    logic [7:0]           sel_data_s;
    logic [7:0]           sel_dest_s;
    logic                 sel_last_s;
    logic                 sel_valid_s;
    logic                 found_s;
    logic [2:0]           pick_s;
    int                   rr_idx_s;

    // Select the granted layer's stream with an AND-OR mux on the one-hot grant.
    always_comb begin
        grant_oh_s  = {LAYERS{1'b0}};
        sel_data_s  = 8'h00;
        sel_dest_s  = 8'h00;
        sel_last_s  = 1'b0;
        sel_valid_s = 1'b0;
        for (int i = 0; i < LAYERS; i++) begin
            grant_oh_s[i] = (grant_q == 3'(i));
            sel_data_s    = sel_data_s | (axis.s_axis_tdata[i*8 +: 8] & {8{grant_oh_s[i]}});
            sel_dest_s    = sel_dest_s | (axis.s_axis_tdest[i*8 +: 8] & {8{grant_oh_s[i]}});
            sel_last_s    = sel_last_s | (axis.s_axis_tlast[i] & grant_oh_s[i]);
            sel_valid_s   = sel_valid_s | (axis.s_axis_tvalid[i] & grant_oh_s[i]);
        end
    end

    // Round-robin search starting one past the last granted layer.
    always_comb begin
        req_s    = axis.s_axis_tvalid & cfg_layer_enable;
        found_s  = 1'b0;
        pick_s   = 3'd0;
        rr_idx_s = 0;
        for (int k = 1; k <= LAYERS; k++) begin
            rr_idx_s = int'(last_grant_q) + k;
            rr_idx_s = (rr_idx_s >= LAYERS) ? (rr_idx_s - LAYERS) : rr_idx_s;
            pick_s   = (!found_s && req_s[rr_idx_s]) ? 3'(rr_idx_s) : pick_s;
            found_s  = found_s | req_s[rr_idx_s];
        end
    end

    // Next-state, stall counter and output stream control.
    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        last_grant_d       = last_grant_q;
        stall_d            = stall_q;
        done_d             = {LAYERS{1'b0}};
        tout_d             = {LAYERS{1'b0}};
        axis.m_axis_tdata  = 8'h00;
        axis.m_axis_tdest  = 8'h00;
        axis.m_axis_tlast  = 1'b0;
        axis.m_axis_tvalid = 1'b0;
        axis.s_axis_tready = {LAYERS{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    grant_d = pick_s;
                    stall_d = {TIMEOUT_W{1'b0}};
                    state_d = ST_PASS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PASS: begin
                axis.m_axis_tdata  = sel_data_s;
                axis.m_axis_tdest  = sel_dest_s;
                axis.m_axis_tlast  = sel_last_s;
                axis.m_axis_tvalid = sel_valid_s;
                axis.s_axis_tready = grant_oh_s & {LAYERS{axis.m_axis_tready}};
                if (sel_valid_s && axis.m_axis_tready) begin
                    stall_d = {TIMEOUT_W{1'b0}};
                    if (sel_last_s) begin
                        done_d       = grant_oh_s;
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_PASS;
                    end
                end else if ((cfg_timeout != {TIMEOUT_W{1'b0}}) && (stall_q == cfg_timeout)) begin
                    state_d = ST_FLUSH;
                end else if (!sel_valid_s && (stall_q != {TIMEOUT_W{1'b1}})) begin
                    // Only an absent source counts as a stall; downstream backpressure holds.
                    stall_d = stall_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                end else begin
                    stall_d = stall_q;
                end
            end
            ST_FLUSH: begin
                axis.m_axis_tdata  = 8'hFF;
                axis.m_axis_tdest  = sel_dest_s;
                axis.m_axis_tlast  = 1'b1;
                axis.m_axis_tvalid = 1'b1;
                if (axis.m_axis_tready) begin
                    tout_d       = grant_oh_s;
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and status registers; reset leaves layer 0 first in round-robin order.
    always_ff @(posedge clk_core or posedge clk_core_rst) begin
        if (clk_core_rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 3'd0;
            last_grant_q <= 3'(LAYERS - 1);
            stall_q      <= {TIMEOUT_W{1'b0}};
            done_q       <= {LAYERS{1'b0}};
            tout_q       <= {LAYERS{1'b0}};
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            stall_q      <= stall_d;
            done_q       <= done_d;
            tout_q       <= tout_d;
        end
    end

    assign status_grant    = grant_q;
    assign status_busy     = (state_q != ST_IDLE);
    assign stat_frame_done = done_q;
    assign stat_timeout    = tout_q;
endmodule

// File: tb/tb_layer_frames_arbiter.sv
// Directed bench for layer_frames_arbiter: per-layer frame sources, an output byte log
// and hand-computed expected sequences for ordering, timeout, backpressure and reset.
module tb_layer_frames_arbiter;
    localparam int L = 3;

    logic          clk_core = 1'b0;
    logic          clk_core_rst = 1'b0;
    logic [L-1:0]  cfg_layer_enable;
    logic [15:0]   cfg_timeout;
    logic [2:0]    status_grant;
    logic          status_busy;
    logic [L-1:0]  stat_frame_done;
    logic [L-1:0]  stat_timeout;

    layer_frames_arbiter_if #(.LAYERS(L)) bus ();

    layer_frames_arbiter #(.LAYERS(L), .TIMEOUT_W(16)) dut (
        .clk_core         (clk_core),
        .clk_core_rst     (clk_core_rst),
        .axis             (bus.slave),
        .cfg_layer_enable (cfg_layer_enable),
        .cfg_timeout      (cfg_timeout),
        .status_grant     (status_grant),
        .status_busy      (status_busy),
        .stat_frame_done  (stat_frame_done),
        .stat_timeout     (stat_timeout)
    );

    always #5 clk_core = ~clk_core;

    int n_checks = 0;
    int n_errors = 0;

    // Source state per layer: byte position, frame length, stall position, repeat flag.
    int pos [L];
    int len [L];
    int stop[L];
    bit act [L];
    bit rep [L];

    logic [7:0] ob_q[$];
    logic [7:0] od_q[$];
    logic       ol_q[$];
    int         oc_q[$];
    int         done_cnt[L];
    int         tout_cnt[L];
    int         cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < L; i++) begin
            bus.s_axis_tdata[i*8 +: 8] = 8'(i*16 + pos[i]);
            bus.s_axis_tdest[i*8 +: 8] = 8'(8'hA0 + i);
            bus.s_axis_tlast[i]        = (pos[i] == len[i] - 1);
            bus.s_axis_tvalid[i]       = act[i] && (pos[i] != stop[i]);
        end
    endtask

    task automatic clear_log();
        ob_q.delete(); od_q.delete(); ol_q.delete(); oc_q.delete();
        for (int i = 0; i < L; i++) begin
            done_cnt[i] = 0;
            tout_cnt[i] = 0;
        end
    endtask

    // One clock: observe at the falling edge, advance sources just after the rising edge.
    task automatic cycle();
        logic [L-1:0] hs;
        @(negedge clk_core);
        hs = bus.s_axis_tvalid & bus.s_axis_tready;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            ob_q.push_back(bus.m_axis_tdata);
            od_q.push_back(bus.m_axis_tdest);
            ol_q.push_back(bus.m_axis_tlast);
            oc_q.push_back(cyc);
        end
        for (int i = 0; i < L; i++) begin
            done_cnt[i] += int'(stat_frame_done[i]);
            tout_cnt[i] += int'(stat_timeout[i]);
        end
        @(posedge clk_core);
        #1;
        cyc++;
        for (int i = 0; i < L; i++) begin
            if (hs[i]) begin
                if (pos[i] == len[i] - 1) begin
                    pos[i] = 0;
                    act[i] = rep[i];
                end else begin
                    pos[i] = pos[i] + 1;
                end
            end
        end
        drive_inputs();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_until_out(input int n, input int budget, input string tag);
        int k = 0;
        while (ob_q.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check(tag, 32'(ob_q.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        clk_core_rst = 1'b1;
        for (int i = 0; i < L; i++) begin
            act[i] = 1'b0; pos[i] = 0; len[i] = 4; stop[i] = -1; rep[i] = 1'b0;
        end
        drive_inputs();
        repeat (2) @(posedge clk_core);
        #1;
        clk_core_rst = 1'b0;
        clear_log();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_layer_enable  = 3'b111;
        cfg_timeout       = 16'd0;
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < L; i++) begin
            act[i] = 1'b0; pos[i] = 0; len[i] = 4; stop[i] = -1; rep[i] = 1'b0;
        end
        drive_inputs();
        #1 clk_core_rst = 1'b1;
        #2;
        check("rst_mvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check("rst_sready", 32'(bus.s_axis_tready), 32'd0);
        check("rst_busy",   32'(status_busy), 32'd0);
        check("rst_grant",  32'(status_grant), 32'd0);
        check("rst_stats",  32'({stat_frame_done, stat_timeout}), 32'd0);
        do_reset();

        // Three simultaneous 4-byte frames: order 0,1,2, contiguous, one idle cycle between.
        for (int i = 0; i < L; i++) act[i] = 1'b1;
        drive_inputs();
        run_until_out(12, 60, "t1_count");
        for (int k = 0; k < 12 && k < ob_q.size(); k++) begin
            check($sformatf("t1_data%0d", k), 32'(ob_q[k]), 32'((k/4)*16 + k%4));
            check($sformatf("t1_last%0d", k), 32'(ol_q[k]), 32'(k%4 == 3));
            if (k % 4 == 0) check($sformatf("t1_dest%0d", k), 32'(od_q[k]), 32'(8'hA0 + k/4));
            if (k > 0) check($sformatf("t1_gap%0d", k), 32'(oc_q[k] - oc_q[k-1]), (k%4 == 0) ? 32'd2 : 32'd1);
        end
        run(2);
        for (int i = 0; i < L; i++) check($sformatf("t1_done%0d", i), 32'(done_cnt[i]), 32'd1);
        check("t1_busy", 32'(status_busy), 32'd0);

        // Layer 1 streams continuously, layer 2 one frame: grant order 1,2,1.
        do_reset();
        act[1] = 1'b1; len[1] = 3; rep[1] = 1'b1;
        act[2] = 1'b1; len[2] = 2;
        drive_inputs();
        run_until_out(8, 60, "t2_count");
        if (ob_q.size() >= 8) begin
            check("t2_dest0", 32'(od_q[0]), 32'hA1);
            check("t2_dest3", 32'(od_q[3]), 32'hA2);
            check("t2_dest5", 32'(od_q[5]), 32'hA1);
            check("t2_last4", 32'(ol_q[4]), 32'd1);
            check("t2_data5", 32'(ob_q[5]), 32'h10);
        end

        // Stall timeout: two bytes then silence, filler byte closes the frame.
        do_reset();
        cfg_timeout = 16'd5;
        act[0] = 1'b1; stop[0] = 2;
        drive_inputs();
        run_until_out(3, 40, "t3_count");
        if (ob_q.size() >= 3) begin
            check("t3_b0",   32'(ob_q[0]), 32'h00);
            check("t3_b1",   32'(ob_q[1]), 32'h01);
            check("t3_l1",   32'(ol_q[1]), 32'd0);
            check("t3_fill", 32'(ob_q[2]), 32'hFF);
            check("t3_flast", 32'(ol_q[2]), 32'd1);
            check("t3_fdest", 32'(od_q[2]), 32'hA0);
            check("t3_delay", 32'(oc_q[2] - oc_q[1]), 32'd7);
        end
        run(2);
        check("t3_tout", 32'(tout_cnt[0]), 32'd1);
        check("t3_done", 32'(done_cnt[0]), 32'd0);
        check("t3_busy", 32'(status_busy), 32'd0);
        // Remaining bytes of the closed frame arrive as a new frame.
        stop[0] = -1;
        drive_inputs();
        run_until_out(5, 20, "t3_resume");
        if (ob_q.size() >= 5) begin
            check("t3_new0", 32'(ob_q[3]), 32'h02);
            check("t3_newl", 32'(ol_q[4]), 32'd1);
        end

        // Downstream backpressure for 20 cycles is not a stall.
        do_reset();
        cfg_timeout = 16'd5;
        act[0] = 1'b1;
        drive_inputs();
        run_until_out(2, 20, "t4_pre");
        bus.m_axis_tready = 1'b0;
        run(20);
        check("t4_hold_busy", 32'(status_busy), 32'd1);
        check("t4_hold_cnt", 32'(ob_q.size()), 32'd2);
        bus.m_axis_tready = 1'b1;
        run_until_out(4, 20, "t4_post");
        if (ob_q.size() >= 4) begin
            check("t4_b2", 32'(ob_q[2]), 32'h02);
            check("t4_b3", 32'(ob_q[3]), 32'h03);
            check("t4_l3", 32'(ol_q[3]), 32'd1);
        end
        run(2);
        check("t4_done", 32'(done_cnt[0]), 32'd1);
        check("t4_tout", 32'(tout_cnt[0]), 32'd0);

        // Disabling the granted layer mid-frame lets that frame finish and blocks later ones.
        do_reset();
        cfg_timeout = 16'd0;
        act[1] = 1'b1; len[1] = 3; rep[1] = 1'b1;
        drive_inputs();
        run_until_out(1, 20, "t5_pre");
        cfg_layer_enable = 3'b101;
        run(30);
        check("t5_count", 32'(ob_q.size()), 32'd3);
        if (ob_q.size() >= 3) begin
            check("t5_b2", 32'(ob_q[2]), 32'h12);
            check("t5_l2", 32'(ol_q[2]), 32'd1);
        end
        check("t5_done", 32'(done_cnt[1]), 32'd1);
        check("t5_busy", 32'(status_busy), 32'd0);
        cfg_layer_enable = 3'b111;

        // Reset during byte 2 drops the frame; layer 0 wins the next arbitration.
        do_reset();
        act[1] = 1'b1;
        drive_inputs();
        run_until_out(2, 20, "t6_pre");
        #2;
        check("t6_pre_valid", 32'(bus.m_axis_tvalid), 32'd1);
        clk_core_rst = 1'b1;
        #1;
        check("t6_valid", 32'(bus.m_axis_tvalid), 32'd0);
        check("t6_busy",  32'(status_busy), 32'd0);
        check("t6_ready", 32'(bus.s_axis_tready), 32'd0);
        check("t6_nolast", 32'(ol_q.size() >= 2 ? ol_q[1] : 1'b1), 32'd0);
        do_reset();
        act[0] = 1'b1; act[1] = 1'b1;
        drive_inputs();
        run_until_out(4, 20, "t6_post");
        if (ob_q.size() >= 4) begin
            check("t6_dest", 32'(od_q[0]), 32'hA0);
            check("t6_b0",   32'(ob_q[0]), 32'h00);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
